// File: rtl/elevator_hall_ctrl.sv
// Single-car SCAN controller for floors 1-4: latches hall calls, moves one floor
// per FLOOR_TICKS, holds the door for DOOR_TICKS and pulses per-floor acks.
module elevator_hall_ctrl #(
  parameter int FLOOR_TICKS = 2000,
  parameter int DOOR_TICKS  = 3000
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic [4:0] call_f4,
  input  logic [4:0] call_f3,
  input  logic [4:0] call_f2,
  input  logic [4:0] call_f1,
  output logic [1:0] floor,
  output logic [4:0] floor_code,
  output logic       dir_up,
  output logic       dir_dn,
  output logic       door_open,
  output logic       moving,
  output logic [3:0] ack_up,
  output logic [3:0] ack_dn
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  localparam int CNT_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int CW      = $clog2(CNT_MAX);

  state_t        state, state_nxt;
  logic [1:0]    floor_nxt, arr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    pend_up, pend_dn, pend_up_nxt, pend_dn_nxt;
  logic [3:0]    req_up, req_dn, pend_up_m, pend_dn_m, any_m;
  logic [3:0]    ack_up_nxt, ack_dn_nxt;
  logic          dir_up_nxt, dir_dn_nxt;
  logic          srv_up, srv_dn, srv_up_nxt, srv_dn_nxt;
  logic          serve_up, serve_dn, enter_door;

  function automatic logic above_of(input logic [3:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) if (i > int'(f)) r |= p[i];
    return r;
  endfunction

  function automatic logic below_of(input logic [3:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) if (i < int'(f)) r |= p[i];
    return r;
  endfunction

  assign req_up    = {1'b0, call_f3[0], call_f2[0], call_f1[0]};
  assign req_dn    = {call_f4[1], call_f3[1], call_f2[1], 1'b0};
  assign pend_up_m = pend_up | req_up;
  assign pend_dn_m = pend_dn | req_dn;
  assign any_m     = pend_up_m | pend_dn_m;

  assign door_open = (state == DOOR);
  assign moving    = (state == MOVE_UP) || (state == MOVE_DN);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    floor_nxt   = floor;
    cnt_nxt     = cnt;
    dir_up_nxt  = dir_up;
    dir_dn_nxt  = dir_dn;
    srv_up_nxt  = srv_up;
    srv_dn_nxt  = srv_dn;
    pend_up_nxt = pend_up_m;
    pend_dn_nxt = pend_dn_m;
    ack_up_nxt  = '0;
    ack_dn_nxt  = '0;
    serve_up    = 1'b0;
    serve_dn    = 1'b0;
    enter_door  = 1'b0;
    arr         = floor;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (any_m[floor]) begin
          enter_door = 1'b1;
          if (dir_up && pend_up_m[floor]) serve_up = 1'b1;
          else if (dir_dn && pend_dn_m[floor]) serve_dn = 1'b1;
          else begin
            serve_up   = 1'b1;
            serve_dn   = 1'b1;
            dir_up_nxt = 1'b0;
            dir_dn_nxt = 1'b0;
          end
        end else if (dir_dn && below_of(any_m, floor)) begin
          state_nxt = MOVE_DN;
        end else if (above_of(any_m, floor)) begin
          state_nxt  = MOVE_UP;
          dir_up_nxt = 1'b1;
          dir_dn_nxt = 1'b0;
        end else if (below_of(any_m, floor)) begin
          state_nxt  = MOVE_DN;
          dir_up_nxt = 1'b0;
          dir_dn_nxt = 1'b1;
        end else begin
          dir_up_nxt = 1'b0;
          dir_dn_nxt = 1'b0;
        end
      end

      MOVE_UP: begin
        if (cnt == CW'(FLOOR_TICKS - 1)) begin
          cnt_nxt   = '0;
          arr       = floor + 2'd1;
          floor_nxt = arr;
          if (pend_up_m[arr]) begin
            enter_door = 1'b1;
            serve_up   = 1'b1;
          end else if (!above_of(any_m, arr)) begin
            // Nothing further up: turn around here, serving a down call if present.
            dir_up_nxt = 1'b0;
            dir_dn_nxt = 1'b1;
            if (pend_dn_m[arr]) begin
              enter_door = 1'b1;
              serve_dn   = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      MOVE_DN: begin
        if (cnt == CW'(FLOOR_TICKS - 1)) begin
          cnt_nxt   = '0;
          arr       = floor - 2'd1;
          floor_nxt = arr;
          if (pend_dn_m[arr]) begin
            enter_door = 1'b1;
            serve_dn   = 1'b1;
          end else if (!below_of(any_m, arr)) begin
            dir_up_nxt = 1'b1;
            dir_dn_nxt = 1'b0;
            if (pend_up_m[arr]) begin
              enter_door = 1'b1;
              serve_up   = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DOOR: begin
        // A press in a served direction at this floor re-acks instead of latching.
        pend_up_nxt[floor] = pend_up_m[floor] & ~srv_up;
        pend_dn_nxt[floor] = pend_dn_m[floor] & ~srv_dn;
        if ((srv_up && req_up[floor]) || (srv_dn && req_dn[floor])) begin
          ack_up_nxt[floor] = srv_up & req_up[floor];
          ack_dn_nxt[floor] = srv_dn & req_dn[floor];
          cnt_nxt           = '0;
        end else if (cnt == CW'(DOOR_TICKS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (enter_door) begin
      state_nxt        = DOOR;
      cnt_nxt          = '0;
      srv_up_nxt       = serve_up;
      srv_dn_nxt       = serve_dn;
      ack_up_nxt[arr]  = serve_up & pend_up_m[arr];
      ack_dn_nxt[arr]  = serve_dn & pend_dn_m[arr];
      pend_up_nxt[arr] = pend_up_m[arr] & ~serve_up;
      pend_dn_nxt[arr] = pend_dn_m[arr] & ~serve_dn;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_1khz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      floor      <= 2'd0;
      floor_code <= 5'b10001;
      cnt        <= '0;
      pend_up    <= '0;
      pend_dn    <= '0;
      dir_up     <= 1'b0;
      dir_dn     <= 1'b0;
      srv_up     <= 1'b0;
      srv_dn     <= 1'b0;
      ack_up     <= '0;
      ack_dn     <= '0;
    end else begin
      state      <= state_nxt;
      floor      <= floor_nxt;
      floor_code <= 5'b10001 + {3'b000, floor_nxt};
      cnt        <= cnt_nxt;
      pend_up    <= pend_up_nxt;
      pend_dn    <= pend_dn_nxt;
      dir_up     <= dir_up_nxt;
      dir_dn     <= dir_dn_nxt;
      srv_up     <= srv_up_nxt;
      srv_dn     <= srv_dn_nxt;
      ack_up     <= ack_up_nxt;
      ack_dn     <= ack_dn_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_hall_ctrl.sv
// Directed bench for elevator_hall_ctrl with short floor/door timers.
module tb_elevator_hall_ctrl;

  localparam int FT = 4;
  localparam int DT = 5;

  logic       clk_1khz = 1'b0;
  logic       rst;
  logic [4:0] call_f4, call_f3, call_f2, call_f1;
  logic [1:0] floor;
  logic [4:0] floor_code;
  logic       dir_up, dir_dn, door_open, moving;
  logic [3:0] ack_up, ack_dn;

  int checks   = 0;
  int failures = 0;

  int         ev_n;
  logic [1:0] ev_floor [8];
  logic [3:0] ev_up    [8];
  logic [3:0] ev_dn    [8];

  elevator_hall_ctrl #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk_1khz  (clk_1khz),
    .rst       (rst),
    .call_f4   (call_f4),
    .call_f3   (call_f3),
    .call_f2   (call_f2),
    .call_f1   (call_f1),
    .floor     (floor),
    .floor_code(floor_code),
    .dir_up    (dir_up),
    .dir_dn    (dir_dn),
    .door_open (door_open),
    .moving    (moving),
    .ack_up    (ack_up),
    .ack_dn    (ack_dn)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_1khz);
      #1;
    end
  endtask

  task automatic do_reset();
    call_f4 = '0; call_f3 = '0; call_f2 = '0; call_f1 = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Steps until the car is idle with no direction, logging every ack pulse.
  task automatic run_log(input int max_cycles);
    int  cyc;
    logic quiet;
    ev_n  = 0;
    cyc   = 0;
    quiet = 1'b0;
    while (!quiet && cyc < max_cycles) begin
      step();
      cyc++;
      if ((ack_up != 4'd0 || ack_dn != 4'd0) && ev_n < 8) begin
        ev_floor[ev_n] = floor;
        ev_up[ev_n]    = ack_up;
        ev_dn[ev_n]    = ack_dn;
        ev_n++;
      end
      quiet = !moving && !door_open && !dir_up && !dir_dn;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL run_log_timeout got busy after %0d cycles, exp idle", cyc);
    end
  endtask

  task automatic check_event(input string name, input int idx,
                             input logic [1:0] f, input logic [3:0] up, input logic [3:0] dn);
    checks++;
    if (idx >= ev_n) begin
      failures++;
      $display("FAIL %s got no event %0d (only %0d), exp floor=%0d", name, idx, ev_n, f);
    end else if (ev_floor[idx] !== f || ev_up[idx] !== up || ev_dn[idx] !== dn) begin
      failures++;
      $display("FAIL %s got floor=%0d up=%b dn=%b exp floor=%0d up=%b dn=%b",
               name, ev_floor[idx], ev_up[idx], ev_dn[idx], f, up, dn);
    end
  endtask

  task automatic test_reset();
    call_f4 = '0; call_f3 = '0; call_f2 = '0; call_f1 = '0;
    rst = 1'b1;
    step(2);
    checks++;
    if ({floor, floor_code, dir_up, dir_dn, door_open, moving, ack_up, ack_dn} !==
        {2'd0, 5'b10001, 4'b0000, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got floor=%0d code=%b du=%b dd=%b door=%b mov=%b au=%b ad=%b exp 0/10001/all zero",
               floor, floor_code, dir_up, dir_dn, door_open, moving, ack_up, ack_dn);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_up();
    do_reset();
    call_f3 = 5'b00001;
    step();
    call_f3 = '0;
    checks++;
    if ({moving, dir_up, dir_dn, floor} !== {3'b110, 2'd0}) begin
      failures++;
      $display("FAIL up_start got mov=%b du=%b dd=%b floor=%0d exp 1 1 0 0", moving, dir_up, dir_dn, floor);
    end
    step(FT);
    checks++;
    if ({floor, floor_code, moving} !== {2'd1, 5'b10010, 1'b1}) begin
      failures++;
      $display("FAIL up_pass_f1 got floor=%0d code=%b mov=%b exp 1 10010 1", floor, floor_code, moving);
    end
    step(FT);
    checks++;
    if ({floor, floor_code, door_open, moving, ack_up, ack_dn} !== {2'd2, 5'b10011, 2'b10, 4'b0100, 4'b0000}) begin
      failures++;
      $display("FAIL up_arrive got floor=%0d code=%b door=%b mov=%b au=%b ad=%b exp 2 10011 1 0 0100 0000",
               floor, floor_code, door_open, moving, ack_up, ack_dn);
    end
    step();
    checks++;
    if ({ack_up, door_open} !== {4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL ack_one_cycle got au=%b door=%b exp 0000 1", ack_up, door_open);
    end
    step(DT - 2);
    checks++;
    if (door_open !== 1'b1) begin
      failures++;
      $display("FAIL door_last_cycle got door=%b exp 1", door_open);
    end
    step();
    checks++;
    if ({door_open, dir_up} !== 2'b01) begin
      failures++;
      $display("FAIL door_close got door=%b du=%b exp 0 1", door_open, dir_up);
    end
    step();
    checks++;
    if ({dir_up, dir_dn, moving, floor} !== {3'b000, 2'd2}) begin
      failures++;
      $display("FAIL idle_nodir got du=%b dd=%b mov=%b floor=%0d exp 0 0 0 2", dir_up, dir_dn, moving, floor);
    end
  endtask

  task automatic test_scan_up();
    do_reset();
    call_f2 = 5'b00001;
    call_f4 = 5'b00010;
    step();
    call_f2 = '0; call_f4 = '0;
    run_log(200);
    checks++;
    if (ev_n !== 2) begin
      failures++;
      $display("FAIL scan_up_count got %0d stops exp 2", ev_n);
    end
    check_event("scan_up_f2", 0, 2'd1, 4'b0010, 4'b0000);
    check_event("scan_up_f4", 1, 2'd3, 4'b0000, 4'b1000);
  endtask

  task automatic test_pass_down_call();
    do_reset();
    call_f2 = 5'b00010;
    call_f4 = 5'b00010;
    step();
    call_f2 = '0; call_f4 = '0;
    run_log(300);
    checks++;
    if (ev_n !== 2) begin
      failures++;
      $display("FAIL pass_dn_count got %0d stops exp 2", ev_n);
    end
    check_event("pass_dn_f4", 0, 2'd3, 4'b0000, 4'b1000);
    check_event("pass_dn_f2", 1, 2'd1, 4'b0000, 4'b0010);
  endtask

  task automatic test_door_restart();
    do_reset();
    call_f1 = 5'b00001;
    step();
    call_f1 = '0;
    checks++;
    if ({door_open, ack_up, ack_dn} !== {1'b1, 4'b0001, 4'b0000}) begin
      failures++;
      $display("FAIL door_f1_open got door=%b au=%b ad=%b exp 1 0001 0000", door_open, ack_up, ack_dn);
    end
    step(2);
    call_f1 = 5'b00001;
    step();
    call_f1 = '0;
    checks++;
    if ({door_open, ack_up} !== {1'b1, 4'b0001}) begin
      failures++;
      $display("FAIL door_reack got door=%b au=%b exp 1 0001", door_open, ack_up);
    end
    for (int i = 1; i < DT; i++) begin
      step();
      checks++;
      if (door_open !== 1'b1) begin
        failures++;
        $display("FAIL door_hold_%0d got door=%b exp 1", i, door_open);
      end
    end
    step();
    checks++;
    if (door_open !== 1'b0) begin
      failures++;
      $display("FAIL door_restart_close got door=%b exp 0", door_open);
    end
    step(2);
    checks++;
    if ({door_open, moving, ack_up} !== {2'b00, 4'b0000}) begin
      failures++;
      $display("FAIL door_no_relatch got door=%b mov=%b au=%b exp 0 0 0000", door_open, moving, ack_up);
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    call_f3 = 5'b00001;
    step();
    call_f3 = '0;
    step(FT + FT / 2);
    checks++;
    if ({floor, moving} !== {2'd1, 1'b1}) begin
      failures++;
      $display("FAIL midmove_pre got floor=%0d mov=%b exp 1 1", floor, moving);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({floor, floor_code, moving, dir_up, dir_dn, door_open} !== {2'd0, 5'b10001, 4'b0000}) begin
      failures++;
      $display("FAIL async_reset got floor=%0d code=%b mov=%b du=%b dd=%b door=%b exp 0 10001 0 0 0 0",
               floor, floor_code, moving, dir_up, dir_dn, door_open);
    end
    step();
    rst = 1'b0;
    step(3 * FT);
    checks++;
    if ({floor, moving, door_open, dir_up} !== {2'd0, 3'b000}) begin
      failures++;
      $display("FAIL calls_lost got floor=%0d mov=%b door=%b du=%b exp 0 0 0 0", floor, moving, door_open, dir_up);
    end
  endtask

  task automatic test_ignored_bits();
    int bad;
    do_reset();
    call_f4 = 5'b10000; call_f3 = 5'b10000; call_f2 = 5'b10000; call_f1 = 5'b10000;
    bad = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      step();
      if (moving || door_open || ack_up != 4'd0 || ack_dn != 4'd0 || floor != 2'd0) bad++;
    end
    call_f4 = '0; call_f3 = '0; call_f2 = '0; call_f1 = '0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL ignored_bits got %0d active cycles exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_scan_up();
    test_pass_down_call();
    test_door_restart();
    test_reset_mid_move();
    test_ignored_bits();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_hall_ctrl.md
Name: elevator_hall_ctrl

Overview:
- Consumes the four hall-call words produced by the outer-button block and runs one car across floors 1-4 with a SCAN (keep-direction) policy.
- Latches calls, moves the car one floor per FLOOR_TICKS, opens the door for DOOR_TICKS at serviced floors and pulses acknowledgements.
- Outputs a 5-bit floor code in the same digit format as the call words, so the display path can show the car position directly.

Parameters:
FLOOR_TICKS, 2000, clk_1khz cycles to travel one floor (min 2)
DOOR_TICKS, 3000, clk_1khz cycles the door stays open (min 2)

Ports:
clk_1khz  in  1  system clock
rst  in  1  asynchronous active-high reset
call_f4  in  5  floor-4 word; bit1 = down request, other bits ignored
call_f3  in  5  floor-3 word; bit0 = up, bit1 = down; bits[4:2] ignored
call_f2  in  5  floor-2 word; bit0 = up, bit1 = down
call_f1  in  5  floor-1 word; bit0 = up request
floor  out  2  car position, 0..3 = floors 1..4
floor_code  out  5  5'b10001 + floor
dir_up  out  1  committed direction up
dir_dn  out  1  committed direction down
door_open  out  1  door open
moving  out  1  car travelling between floors
ack_up  out  4  one-cycle pulse per floor, up call serviced (bit i = floor i+1; bit3 always 0)
ack_dn  out  4  one-cycle pulse per floor, down call serviced (bit0 always 0)

Behaviour:
- Reset (async, any state): floor=0, floor_code=5'b10001, state IDLE, pend_up=pend_dn=0, counters 0, dir_up=dir_dn=door_open=moving=0, ack_up=ack_dn=0.
- Call latch: each rising clk_1khz, pend_up[i] |= up bit and pend_dn[i] |= down bit. Latch set has priority over the service-clear only when the car is not stopped with the door open at that floor in that direction. A press at the current floor while the door is open re-acks and restarts the door timer.
- "above" = any pend bit at a floor > floor; "below" = any pend bit at a floor < floor.
- States:
  - IDLE: if any pend at the current floor, go to DOOR (serve that floor). Else if above, go to MOVE_UP with dir_up=1. Else if below, go to MOVE_DN with dir_dn=1. Else stay, with dir_up=dir_dn=0.
  - MOVE_UP / MOVE_DN: moving=1; the counter counts to FLOOR_TICKS-1, then floor±1 on that edge and the counter clears. On arrival, stop (go to DOOR) if:
    - a call at that floor matches the direction; or
    - no further calls exist in the direction (then the opposite-direction call is served).
    Otherwise continue. Floor never passes 3 or goes below 0: at floor 3 direction forces down, at floor 0 it forces up.
  - DOOR: door_open=1, moving=0.
    - On entry cycle: ack and clear the served direction's pend bit at that floor (both bits if the car becomes idle-directionless).
    - The counter counts DOOR_TICKS cycles, then go to IDLE with direction kept. IDLE's next decision prefers the kept direction if calls remain that way, else reverses.
- ack pulses are exactly one cycle, coincident with the entry into DOOR or a door-timer restart.
- floor_code is registered together with floor (same cycle).
- dir_up and dir_dn are never both 1.
- Reset mid-move or mid-door: immediate return to reset values; pending calls are lost.

Test Plan:
- Reset with call_f3=5'b00001 held 1 cycle → car moves up. After 2*FLOOR_TICKS: floor=2, floor_code=5'b10011, ack_up=4'b0100 pulse, door_open for DOOR_TICKS, then IDLE with dir bits 0.
- Car at floor 0, calls f2 up and f4 down latched together → stops at floor 1 (ack_up[1]), continues to floor 3 (ack_dn[3]). Never stops at floor 2.
- Car moving up from floor 0, call_f2 down only, plus call_f4 down → passes floor 1, serves floor 3 first, then returns to floor 1 (ack_dn[1]).
- call_f1 up pressed while the door is open at floor 0 → ack_up[0] pulses again and the door stays open DOOR_TICKS from the press.
- Assert rst midway through MOVE_UP (counter ≈ FLOOR_TICKS/2) → all outputs reset asynchronously. With no calls after release, the car stays IDLE at floor 0.
- Bits[4:2]=3'b100 on all words with bits[1:0]=0 → no movement, no acks.
